// File: rtl/trace_pkg.sv
// trace_pkg: shared constants, read FSM states and helpers for the trace frame buffer
//   WPF  words per TPIU frame, IW its index width
//   WW   packet word width, DCW drop counter width
package trace_pkg;
    localparam int WPF = 8;
    localparam int IW = $clog2(WPF);
    localparam int WW = 16;
    localparam int DCW = 16;
    typedef enum logic [1:0] {IDLE, LOAD, SEND} rd_state_t;
    function automatic logic [DCW-1:0] sat_inc(input logic [DCW-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/trace_frame_buffer_ctrl_if.sv
// trace_frame_buffer_ctrl_if: host-side output word stream
//   oValid/oWd/oLast  word, valid and end-of-frame marker (source -> sink)
//   oReady            sink accepts the word when oValid&oReady
interface trace_frame_buffer_ctrl_if;
    import trace_pkg::*;
    logic oValid;
    logic [WW-1:0] oWd;
    logic oLast;
    logic oReady;
    modport master(output oValid, oWd, oLast, input oReady);
    modport slave(input oValid, oWd, oLast, output oReady);
endinterface

// File: rtl/frame_store_ram.sv
// frame_store_ram: simple dual-port frame store, one write port, one registered read port
//   we/waddr/wdata  write port
//   re/raddr/rdata  read port, rdata updates one clock after re and holds otherwise
module frame_store_ram #(
    parameter int DEPTH = 64,
    parameter int DW = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/trace_frame_buffer_ctrl.sv
// trace_frame_buffer_ctrl: N-slot trace frame store with commit/drop accounting and frame read-out
//   clk, rst                     clock, asynchronous active-high reset
//   sync, wrEn, wrWd             trace sync qualifier and packet word strobe/data
//   wrReset, wrCommit, flush     discard partial frame, close frame, synchronous clear
//   out                          host-side word stream (oValid/oWd/oLast/oReady)
//   framesQueued, overflow, dropCnt  committed frame count, sticky full-drop flag, drop counter
module trace_frame_buffer_ctrl
    import trace_pkg::*;
#(
    parameter int SLOTS = 8,
    localparam int SW = $clog2(SLOTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sync,
    input  logic                       wrEn,
    input  logic [WW-1:0]              wrWd,
    input  logic                       wrReset,
    input  logic                       wrCommit,
    input  logic                       flush,
    trace_frame_buffer_ctrl_if.master  out,
    output logic [SW:0]                framesQueued,
    output logic                       overflow,
    output logic [DCW-1:0]             dropCnt
);
    localparam logic [SW:0] FULL_CNT = (SW+1)'(SLOTS);
    localparam logic [IW:0] WPF_CNT = (IW+1)'(WPF);
    logic [SW-1:0] w_slot, r_slot, r_slot_n;
    logic [IW:0] w_idx, idx_n;
    logic [IW-1:0] r_idx, r_idx_n;
    logic [SW:0] count;
    logic drop_pending, pend_n;
    logic full, wr_blank, wr_ok, wr_drop, commit, commit_ok, commit_bad;
    logic valid_n, last_n, read_done;
    logic [WW-1:0] rd_data;
    rd_state_t state, state_n;
    // A commit sees the word written in the same cycle, so it is judged on idx_n/pend_n.
    always_comb begin
        full = count == FULL_CNT;
        wr_blank = !sync || wrReset;
        wr_ok = !wr_blank && wrEn && !full && w_idx != WPF_CNT;
        wr_drop = !wr_blank && wrEn && !wr_ok;
        idx_n = w_idx + (IW+1)'(wr_ok);
        pend_n = drop_pending || wr_drop;
        commit = !wr_blank && wrCommit;
        commit_ok = commit && idx_n == WPF_CNT && !pend_n && !full;
        commit_bad = commit && !commit_ok;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_slot <= '0;
            w_idx <= '0;
            drop_pending <= 1'b0;
            count <= '0;
            overflow <= 1'b0;
            dropCnt <= '0;
        end else begin
            w_slot <= flush ? '0 : w_slot + SW'(commit_ok);
            w_idx <= flush || wr_blank || commit ? '0 : idx_n;
            drop_pending <= !flush && !wr_blank && !commit && pend_n;
            count <= flush ? '0 : count + (SW+1)'(commit_ok) - (SW+1)'(read_done);
            overflow <= !flush && (overflow || (commit_bad && full));
            dropCnt <= flush ? '0 : commit_bad ? sat_inc(dropCnt) : dropCnt;
        end
    end
    assign framesQueued = count;
    always_comb begin
        state_n = state;
        r_idx_n = r_idx;
        r_slot_n = r_slot;
        valid_n = out.oValid;
        last_n = out.oLast;
        read_done = 1'b0;
        case (state)
            IDLE: begin
                state_n = count != '0 ? LOAD : IDLE;
                r_idx_n = '0;
            end
            LOAD: begin
                state_n = SEND;
                valid_n = 1'b1;
                last_n = r_idx == IW'(WPF - 1);
            end
            SEND: if (out.oReady) begin
                valid_n = 1'b0;
                last_n = 1'b0;
                read_done = out.oLast;
                state_n = out.oLast ? IDLE : LOAD;
                r_idx_n = out.oLast ? r_idx : r_idx + 1'b1;
                r_slot_n = out.oLast ? r_slot + 1'b1 : r_slot;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r_idx <= '0;
            r_slot <= '0;
            out.oValid <= 1'b0;
            out.oLast <= 1'b0;
        end else begin
            state <= flush ? IDLE : state_n;
            r_idx <= flush ? '0 : r_idx_n;
            r_slot <= flush ? '0 : r_slot_n;
            out.oValid <= !flush && valid_n;
            out.oLast <= !flush && last_n;
        end
    end
    // RAM output register has no reset, so the word is masked while nothing is offered.
    assign out.oWd = out.oValid ? rd_data : '0;
    frame_store_ram #(.DEPTH(SLOTS * WPF), .DW(WW)) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr ({w_slot, w_idx[IW-1:0]}),
        .wdata (wrWd),
        .re    (state == LOAD),
        .raddr ({r_slot, r_idx}),
        .rdata (rd_data)
    );
endmodule
